// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: FSM state type and round-robin pick helper for tick_timer_arbiter
package tick_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tt_state_t;
  localparam int RR_MAX = 32;
  typedef struct packed {
    logic valid;
    int   idx;
  } rr_pick_t;
  // first set bit of req[n-1:0] searching upward from last+1, wrapping
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input int last, input int n);
    rr_pick_t r;
    int k;
    r = '0;
    for (int j = 1; j <= RR_MAX; j++) begin
      k = (last + j) % n;
      if (j <= n && !r.valid && req[k[4:0]]) begin
        r.valid = 1'b1;
        r.idx = k;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/tick_timer_arbiter_prescaler.sv
// tick_prescaler: 0..PRESCALE-1 counter with clear/enable and a registered one-cycle wrap pulse
module tick_prescaler #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int CNT_W = $clog2(PRESCALE);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d, last;
  always_comb begin
    last = cnt_q == CNT_W'(PRESCALE - 1);
    cnt_d = clr ? '0 : !en ? cnt_q : last ? '0 : cnt_q + 1'b1;
    wrap_d = !clr && en && last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign wrap = wrap_q;
endmodule

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: round-robin sharing of one prescaled tick timer among N_REQ requesters
// TICK_TIMER_ABORT_EN: when defined, dropping the granted req during RUN aborts the delay
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int PRESCALE = 50_000_000,
  parameter int TICK_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][TICK_W-1:0]  req_ticks,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic                          tick,
  output logic                          busy
);
  localparam int IDX_W = $clog2(N_REQ);
  tt_state_t state_q, state_d;
  logic sync_ena_q;
  logic [IDX_W-1:0] rr_last_q, rr_last_d, idx_q, idx_d, pick_idx;
  logic [TICK_W-1:0] rem_q, rem_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic wrap;
  rr_pick_t pick;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (state_q != RUN || !sync_ena_q),
    .en  (sync_ena_q),
    .wrap(wrap)
  );
  assign tick = wrap && state_q == RUN;
  assign busy = state_q != IDLE;
  assign gnt = gnt_q;
  assign done = done_q;
  always_comb begin
    pick = rr_pick(RR_MAX'(req), int'(rr_last_q), N_REQ);
    pick_idx = IDX_W'(pick.idx);
    state_d = state_q;
    rr_last_d = rr_last_q;
    idx_d = idx_q;
    rem_d = rem_q;
    gnt_d = gnt_q;
    done_d = '0;
    if (state_q == IDLE) begin
      if (sync_ena_q && pick.valid) begin
        state_d = RUN;
        idx_d = pick_idx;
        rr_last_d = pick_idx;
        rem_d = req_ticks[pick_idx];
        gnt_d = N_REQ'(1) << pick_idx;
      end
    end else if (state_q == RUN) begin
`ifdef TICK_TIMER_ABORT_EN
      if (!req[idx_q]) begin
        state_d = IDLE;
        gnt_d = '0;
      end else
`endif
      // a zero count spends one RUN cycle so done lands one cycle after grant
      if (rem_q == '0 || (tick && rem_q == TICK_W'(1))) begin
        state_d = DONE;
        rem_d = '0;
        done_d = gnt_q;
      end else if (tick) begin
        rem_d = rem_q - 1'b1;
      end
    end else begin
      state_d = IDLE;
      gnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_ena_q <= 1'b0;
      rr_last_q <= IDX_W'(N_REQ - 1);
      idx_q <= '0;
      rem_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      sync_ena_q <= ena;
      rr_last_q <= rr_last_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb_tick_timer_arbiter: directed self-checking bench for tick_timer_arbiter with PRESCALE=4
module tb_tick_timer_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic [3:0] req = '0;
  logic [3:0][7:0] req_ticks = '0;
  logic [3:0] gnt, done;
  logic tick, busy;
  int checks = 0;
  int errors = 0;
  logic tk[0:31];
  logic bz[0:31];
  logic [3:0] dn[0:31];
  logic [3:0] gn[0:31];
  tick_timer_arbiter #(.N_REQ(4), .PRESCALE(4), .TICK_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_ticks(req_ticks),
    .gnt(gnt), .done(done), .tick(tick), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_gnt();
    int ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (gnt != '0) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("gnt_seen", ok, 1);
  endtask
  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && gnt == '0) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("idle_seen", ok, 1);
  endtask
  // index k holds outputs at cycle G+k; input edits at index k apply from the next edge
  task automatic window(input int n, input int off_at, input int on_at, input int rq_off_at, input bit drop);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) step();
      tk[k] = tick;
      dn[k] = done;
      gn[k] = gnt;
      bz[k] = busy;
      if (drop && done != '0) req = req & ~done;
      if (k == off_at) ena = 1'b0;
      if (k == on_at) ena = 1'b1;
      if (k == rq_off_at) req = '0;
    end
  endtask
  initial begin
    int cnt;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    // 1: single requester, 3 ticks
    req_ticks[0] = 8'd3;
    ena = 1'b1;
    req = 4'b0001;
    wait_gnt();
    window(16, -1, -1, -1, 1'b1);
    chk("t1_gnt", gn[0], 4'b0001);
    chk("t1_busy", bz[0], 1);
    for (int k = 0; k <= 15; k++) chk($sformatf("t1_tick%0d", k), tk[k], (k == 4 || k == 8 || k == 12) ? 1 : 0);
    chk("t1_done_early", dn[12], 0);
    chk("t1_done", dn[13], 4'b0001);
    chk("t1_gnt_hold", gn[13], 4'b0001);
    chk("t1_gnt_fall", gn[14], 0);
    chk("t1_idle", bz[14], 0);
    // 2: all requesting, one tick each, fresh round-robin pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_ticks = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    wait_gnt();
    for (int i = 0; i < 5; i++) begin
      window(7, -1, -1, (i == 4) ? 6 : -1, 1'b0);
      chk($sformatf("t2_gnt%0d", i), gn[0], 32'(4'b0001 << (i % 4)));
      chk($sformatf("t2_done_early%0d", i), dn[4], 0);
      chk($sformatf("t2_done%0d", i), dn[5], 32'(4'b0001 << (i % 4)));
      chk($sformatf("t2_fall%0d", i), gn[6], 0);
      chk($sformatf("t2_next%0d", i), gn[7], (i == 4) ? 0 : 32'(4'b0001 << ((i + 1) % 4)));
    end
    // 3: zero-tick request
    req_ticks[2] = 8'd0;
    req = 4'b0100;
    wait_gnt();
    window(4, -1, -1, -1, 1'b1);
    chk("t3_gnt", gn[0], 4'b0100);
    chk("t3_done0", dn[0], 0);
    chk("t3_done", dn[1], 4'b0100);
    chk("t3_fall", gn[2], 0);
    cnt = 0;
    for (int k = 0; k <= 4; k++) cnt += int'(tk[k]);
    chk("t3_no_ticks", cnt, 0);
    // 4: enable paused for 10 synchronized cycles from G+2
    req_ticks[0] = 8'd2;
    req = 4'b0001;
    wait_gnt();
    window(24, 1, 11, -1, 1'b1);
    chk("t4_gnt", gn[0], 4'b0001);
    chk("t4_tick_a", tk[16], 1);
    chk("t4_tick_b", tk[20], 1);
    cnt = 0;
    for (int k = 0; k <= 24; k++) cnt += int'(tk[k]);
    chk("t4_tick_count", cnt, 2);
    chk("t4_done_early", dn[20], 0);
    chk("t4_done", dn[21], 4'b0001);
    chk("t4_fall", gn[22], 0);
    // 5: reset mid-RUN restores rr_last so requester 0 beats requester 1
    req_ticks[0] = 8'd3;
    req = 4'b0001;
    wait_gnt();
    window(6, -1, -1, -1, 1'b0);
    chk("t5_gnt", gn[0], 4'b0001);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_tick", tick, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    req = 4'b0011;
    wait_gnt();
    chk("t5_regrant", gnt, 4'b0001);
    req = '0;
    wait_idle();
    // 6: granted requester drops req during RUN
    req_ticks[1] = 8'd5;
    req = 4'b0010;
    wait_gnt();
    window(25, -1, -1, 6, 1'b1);
    chk("t6_gnt", gn[0], 4'b0010);
    cnt = 0;
    for (int k = 0; k <= 25; k++) cnt += (dn[k] != '0) ? 1 : 0;
`ifdef TICK_TIMER_ABORT_EN
    chk("t6_abort_gnt", gn[8], 0);
    chk("t6_abort_busy", bz[8], 0);
    chk("t6_abort_nodone", cnt, 0);
`else
    chk("t6_done", dn[21], 4'b0010);
    chk("t6_fall", gn[22], 0);
    chk("t6_done_count", cnt, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
